// File: rtl/axi_stream_remove_header_if.sv
// Bundle of the packet input, packet output, strip-descriptor and header-report
// signals of axi_stream_remove_header; master drives the stream, slave is the stripper.
interface axi_stream_remove_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                    valid_in;
  logic                    ready_in;
  logic                    last_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;

  logic                    valid_out;
  logic                    ready_out;
  logic                    last_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;

  logic                    valid_strip;
  logic                    ready_strip;
  logic [BYTE_CNT_WD:0]    byte_strip_cnt;

  logic                    header_valid;
  logic [DATA_WD-1:0]      header_data;
  logic [DATA_BYTE_WD-1:0] header_keep;
  logic                    drop_pkt;

  modport slave (
    input  valid_in, last_in, data_in, keep_in,
    output ready_in,
    output valid_out, last_out, data_out, keep_out,
    input  ready_out,
    input  valid_strip, byte_strip_cnt,
    output ready_strip,
    output header_valid, header_data, header_keep, drop_pkt
  );

  modport master (
    output valid_in, last_in, data_in, keep_in,
    input  ready_in,
    input  valid_out, last_out, data_out, keep_out,
    output ready_out,
    output valid_strip, byte_strip_cnt,
    input  ready_strip,
    input  header_valid, header_data, header_keep, drop_pkt
  );
endinterface

// File: rtl/axi_stream_remove_header.sv
// Strips an N-byte header (N from a per-packet descriptor) off the front of an
// MSB-first AXI-Stream packet, re-aligning the payload to the top of each beat.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input logic                       clk,
  input logic                       rst,
  axi_stream_remove_header_if.slave bus
);
  localparam int CW = BYTE_CNT_WD + 1;
  localparam logic [CW-1:0]           DBW_C    = CW'(DATA_BYTE_WD);
  localparam logic [DATA_BYTE_WD-1:0] KEEP_ALL = '1;
  localparam logic [DATA_WD-1:0]      DATA_ALL = '1;

  typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

  state_t                  state_q;
  logic [CW-1:0]           n_q, s_q, flush_cnt_q;
  logic [DATA_WD-1:0]      residue_q, data_out_q, header_data_q;
  logic [DATA_BYTE_WD-1:0] keep_out_q, header_keep_q;
  logic                    valid_out_q, last_out_q, header_valid_q, drop_pkt_q;

  logic                    out_free, ready_in_w, fire_in;
  logic [CW-1:0]           k_in, n_clamp, r_cnt;
  logic [CW+2:0]           n_bits, s_bits, r_bits;

  function automatic logic [DATA_BYTE_WD-1:0] keep_msbs(input logic [CW-1:0] m);
    return ~(KEEP_ALL >> m);
  endfunction

  assign out_free   = !valid_out_q || bus.ready_out;
  assign ready_in_w = ((state_q == FIRST) || (state_q == STREAM)) && out_free;
  assign fire_in    = bus.valid_in && ready_in_w;

  assign k_in    = CW'($countones(bus.keep_in));
  assign n_clamp = (bus.byte_strip_cnt > DBW_C) ? DBW_C : bus.byte_strip_cnt;
  assign r_cnt   = DBW_C - s_q;
  assign n_bits  = {n_q, 3'b000};
  assign s_bits  = {s_q, 3'b000};
  assign r_bits  = {r_cnt, 3'b000};

  assign bus.ready_in     = ready_in_w;
  assign bus.ready_strip  = (state_q == IDLE);
  assign bus.valid_out    = valid_out_q;
  assign bus.data_out     = data_out_q;
  assign bus.keep_out     = keep_out_q;
  assign bus.last_out     = last_out_q;
  assign bus.header_valid = header_valid_q;
  assign bus.header_data  = header_data_q;
  assign bus.header_keep  = header_keep_q;
  assign bus.drop_pkt     = drop_pkt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      n_q            <= '0;
      s_q            <= '0;
      flush_cnt_q    <= '0;
      residue_q      <= '0;
      data_out_q     <= '0;
      keep_out_q     <= '0;
      valid_out_q    <= 1'b0;
      last_out_q     <= 1'b0;
      header_valid_q <= 1'b0;
      header_data_q  <= '0;
      header_keep_q  <= '0;
      drop_pkt_q     <= 1'b0;
    end else begin
      header_valid_q <= 1'b0;
      drop_pkt_q     <= 1'b0;
      if (bus.ready_out) valid_out_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (bus.valid_strip) begin
            n_q     <= n_clamp;
            s_q     <= CW'(n_clamp[BYTE_CNT_WD-1:0]);
            state_q <= FIRST;
          end
        end

        FIRST: begin
          if (fire_in) begin
            header_valid_q <= 1'b1;
            header_data_q  <= bus.data_in & ~(DATA_ALL >> n_bits);
            header_keep_q  <= keep_msbs(n_q);
            if (bus.last_in) begin
              state_q <= IDLE;
              if (k_in <= n_q) begin
                drop_pkt_q <= 1'b1;
              end else begin
                valid_out_q <= 1'b1;
                data_out_q  <= bus.data_in << n_bits;
                keep_out_q  <= bus.keep_in << n_q;
                last_out_q  <= 1'b1;
              end
            end else begin
              state_q <= STREAM;
              if (n_q == '0) begin
                valid_out_q <= 1'b1;
                data_out_q  <= bus.data_in;
                keep_out_q  <= bus.keep_in;
                last_out_q  <= 1'b0;
              end else if (s_q != '0) begin
                residue_q <= bus.data_in << n_bits;
              end
            end
          end
        end

        STREAM: begin
          if (fire_in) begin
            valid_out_q <= 1'b1;
            if (s_q == '0) begin
              data_out_q <= bus.data_in;
              keep_out_q <= bus.keep_in;
              last_out_q <= bus.last_in;
              if (bus.last_in) state_q <= IDLE;
            end else begin
              // residue fills the top R bytes, the beat's top S bytes slide in below
              data_out_q <= residue_q | (bus.data_in >> r_bits);
              residue_q  <= bus.data_in << s_bits;
              if (bus.last_in && (k_in <= s_q)) begin
                keep_out_q <= keep_msbs(r_cnt + k_in);
                last_out_q <= 1'b1;
                state_q    <= IDLE;
              end else begin
                keep_out_q <= KEEP_ALL;
                last_out_q <= 1'b0;
                if (bus.last_in) begin
                  flush_cnt_q <= k_in - s_q;
                  state_q     <= FLUSH;
                end
              end
            end
          end
        end

        FLUSH: begin
          // first the full beat drains, then the residue beat; leave once the latter is taken
          if (valid_out_q && bus.ready_out && last_out_q) begin
            state_q <= IDLE;
          end else if (out_free) begin
            valid_out_q <= 1'b1;
            data_out_q  <= residue_q;
            keep_out_q  <= keep_msbs(flush_cnt_q);
            last_out_q  <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Directed bench for axi_stream_remove_header: hand-computed beats, header
// captures, drops, an output stall, and a mid-packet reset.
module tb_axi_stream_remove_header;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  axi_stream_remove_header_if #(.DATA_WD(32)) bus ();
  axi_stream_remove_header #(.DATA_WD(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Output / header / drop capture, sampled mid-cycle.
  logic [31:0] qd[$];
  logic [3:0]  qk[$];
  logic        ql[$];
  logic [31:0] hd[$];
  logic [3:0]  hk[$];
  int          drops = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_out && bus.ready_out) begin
        qd.push_back(bus.data_out);
        qk.push_back(bus.keep_out);
        ql.push_back(bus.last_out);
      end
      if (bus.header_valid) begin
        hd.push_back(bus.header_data);
        hk.push_back(bus.header_keep);
      end
      if (bus.drop_pkt) drops++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input logic [2:0] n);
    bit acc;
    acc = 1'b0;
    bus.valid_strip    = 1'b1;
    bus.byte_strip_cnt = n;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = bus.ready_strip;
      tick();
    end
    bus.valid_strip = 1'b0;
    chk("desc_accept", acc, 1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit acc;
    acc = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.keep_in  = k;
    bus.last_in  = l;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = bus.ready_in;
      tick();
    end
    bus.valid_in = 1'b0;
    chk("beat_accept", acc, 1);
  endtask

  task automatic expect_beat(input int idx, input string tag,
                             input logic [31:0] d, input logic [3:0] k, input logic l);
    chk({tag, "_present"}, qd.size() > idx, 1);
    if (qd.size() > idx) begin
      chk({tag, "_data"}, qd[idx], d);
      chk({tag, "_keep"}, qk[idx], k);
      chk({tag, "_last"}, ql[idx], l);
    end
  endtask

  task automatic expect_hdr(input int idx, input string tag,
                            input logic [31:0] d, input logic [3:0] k);
    chk({tag, "_present"}, hd.size() > idx, 1);
    if (hd.size() > idx) begin
      chk({tag, "_data"}, hd[idx], d);
      chk({tag, "_keep"}, hk[idx], k);
    end
  endtask

  int          b, h, dcount, stall_bad, bad, nl, nin;
  logic [31:0] rd, sd;
  logic [3:0]  rk, sk;
  logic        rl, sl, sv;
  logic [7:0]  exp_bytes[$];
  logic [7:0]  got_bytes[$];

  initial begin
    bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
    bus.ready_out = 1'b1; bus.valid_strip = 1'b0; bus.byte_strip_cnt = '0;
    rst = 1'b1;
    tick(); tick();

    // reset state
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_keep_out", bus.keep_out, 0);
    chk("rst_last_out", bus.last_out, 0);
    chk("rst_header_valid", bus.header_valid, 0);
    chk("rst_header_data", bus.header_data, 0);
    chk("rst_header_keep", bus.header_keep, 0);
    chk("rst_drop", bus.drop_pkt, 0);
    chk("rst_ready_strip", bus.ready_strip, 1);
    chk("rst_ready_in", bus.ready_in, 0);
    rst = 1'b0;
    tick();

    // N=1, two full beats -> full beat then 3-byte flush
    b = qd.size(); h = hd.size();
    send_desc(3'd1);
    send_beat(32'hAABBCCDD, 4'hF, 1'b0);
    send_beat(32'h11223344, 4'hF, 1'b1);
    repeat (4) tick();
    chk("t1_nbeats", qd.size() - b, 2);
    expect_beat(b,     "t1_b0", 32'hBBCCDD11, 4'hF, 1'b0);
    expect_beat(b + 1, "t1_b1", 32'h22334400, 4'hE, 1'b1);
    expect_hdr(h, "t1_hdr", 32'hAA000000, 4'h8);

    // N=0 pass-through with one-cycle latency
    b = qd.size(); h = hd.size();
    send_desc(3'd0);
    send_beat(32'h01020304, 4'hF, 1'b0);
    chk("t2_lat_valid", bus.valid_out, 1);
    chk("t2_lat_data", bus.data_out, 32'h01020304);
    chk("t2_lat_keep", bus.keep_out, 4'hF);
    send_beat(32'h05060708, 4'hF, 1'b0);
    send_beat(32'h090A0B0C, 4'h8, 1'b1);
    repeat (3) tick();
    chk("t2_nbeats", qd.size() - b, 3);
    expect_beat(b,     "t2_b0", 32'h01020304, 4'hF, 1'b0);
    expect_beat(b + 1, "t2_b1", 32'h05060708, 4'hF, 1'b0);
    expect_beat(b + 2, "t2_b2", 32'h090A0B0C, 4'h8, 1'b1);
    expect_hdr(h, "t2_hdr", 32'h00000000, 4'h0);

    // N=4: whole first beat is header
    b = qd.size(); h = hd.size();
    send_desc(3'd4);
    send_beat(32'hDEADBEEF, 4'hF, 1'b0);
    send_beat(32'h01020304, 4'hC, 1'b1);
    repeat (3) tick();
    chk("t3_nbeats", qd.size() - b, 1);
    expect_beat(b, "t3_b0", 32'h01020304, 4'hC, 1'b1);
    expect_hdr(h, "t3_hdr", 32'hDEADBEEF, 4'hF);

    // N=3, single 2-byte packet -> dropped
    b = qd.size(); h = hd.size(); dcount = drops;
    send_desc(3'd3);
    send_beat(32'h12345678, 4'hC, 1'b1);
    repeat (3) tick();
    chk("t4_drop", drops - dcount, 1);
    chk("t4_nbeats", qd.size() - b, 0);
    chk("t4_hdr_count", hd.size() - h, 1);
    if (hd.size() > h) chk("t4_hdr_keep", hk[h], 4'hE);

    // N=1, single 3-byte last beat (k > N)
    b = qd.size();
    send_desc(3'd1);
    send_beat(32'hA1B2C3D4, 4'hE, 1'b1);
    repeat (3) tick();
    chk("t5_nbeats", qd.size() - b, 1);
    expect_beat(b, "t5_b0", 32'hB2C3D400, 4'hC, 1'b1);

    // N=2, last beat with k <= S merges into residue beat
    b = qd.size();
    send_desc(3'd2);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h55667788, 4'h8, 1'b1);
    repeat (3) tick();
    chk("t6_nbeats", qd.size() - b, 1);
    expect_beat(b, "t6_b0", 32'h33445566, 4'hE, 1'b1);

    // descriptor 7 clamps to 4
    b = qd.size(); h = hd.size();
    send_desc(3'd7);
    send_beat(32'hCAFEF00D, 4'hF, 1'b0);
    send_beat(32'h0BADBEEF, 4'hF, 1'b1);
    repeat (3) tick();
    chk("t7_nbeats", qd.size() - b, 1);
    expect_beat(b, "t7_b0", 32'h0BADBEEF, 4'hF, 1'b1);
    expect_hdr(h, "t7_hdr", 32'hCAFEF00D, 4'hF);

    // N=2, 512 random beats with a 5-cycle output stall
    b = qd.size(); nin = 0; stall_bad = 0; sv = 1'b0;
    send_desc(3'd2);
    for (int i = 0; i < 512; i++) begin
      rd = $urandom;
      rl = (i == 511);
      rk = rl ? ~(4'hF >> $urandom_range(1, 4)) : 4'hF;
      for (int j = 0; j < 4; j++) begin
        if (rk[3-j]) begin
          if (nin >= 2) exp_bytes.push_back(rd[31-8*j -: 8]);
          nin++;
        end
      end
      send_beat(rd, rk, rl);
      if (i == 200) begin
        bus.ready_out = 1'b0;
        sv = bus.valid_out; sd = bus.data_out; sk = bus.keep_out; sl = bus.last_out;
        repeat (5) begin
          tick();
          if (bus.valid_out !== 1'b1 || bus.data_out !== sd ||
              bus.keep_out !== sk || bus.last_out !== sl) stall_bad++;
        end
        bus.ready_out = 1'b1;
      end
    end
    repeat (5) tick();
    chk("t8_stall_valid", sv, 1);
    chk("t8_stall_stable", stall_bad, 0);
    nl = 0;
    for (int j = b; j < qd.size(); j++) begin
      if (ql[j]) nl++;
      for (int m = 0; m < 4; m++)
        if (qk[j][3-m]) got_bytes.push_back(qd[j][31-8*m -: 8]);
    end
    chk("t8_byte_count", got_bytes.size(), exp_bytes.size());
    bad = 0;
    for (int j = 0; j < got_bytes.size() && j < exp_bytes.size(); j++)
      if (got_bytes[j] !== exp_bytes[j]) bad++;
    chk("t8_byte_errors", bad, 0);
    chk("t8_last_count", nl, 1);
    if (qd.size() > b) chk("t8_final_last", ql[qd.size()-1], 1);

    // reset in STREAM with a stalled output beat, then a clean N=1 packet
    send_desc(3'd1);
    send_beat(32'h99887766, 4'hF, 1'b0);
    send_beat(32'h55443322, 4'hF, 1'b0);
    bus.ready_out = 1'b0;
    chk("t9_pre_valid", bus.valid_out, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t9_rst_valid", bus.valid_out, 0);
    chk("t9_rst_data", bus.data_out, 0);
    chk("t9_rst_keep", bus.keep_out, 0);
    chk("t9_rst_last", bus.last_out, 0);
    chk("t9_rst_hdr_data", bus.header_data, 0);
    chk("t9_rst_hdr_keep", bus.header_keep, 0);
    chk("t9_rst_ready_in", bus.ready_in, 0);
    tick();
    rst = 1'b0;
    bus.ready_out = 1'b1;
    tick();
    chk("t9_idle_ready_strip", bus.ready_strip, 1);
    b = qd.size(); h = hd.size();
    send_desc(3'd1);
    send_beat(32'h10203040, 4'hF, 1'b0);
    send_beat(32'h50607080, 4'hC, 1'b1);
    repeat (4) tick();
    chk("t9_nbeats", qd.size() - b, 2);
    expect_beat(b,     "t9_b0", 32'h20304050, 4'hF, 1'b0);
    expect_beat(b + 1, "t9_b1", 32'h60708000, 4'h8, 1'b1);
    expect_hdr(h, "t9_hdr", 32'h10000000, 4'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
